// File: rtl/pdm_sched_pkg.sv
// Shared types and constants for the PDM frame scheduler: FSM states,
// byte-pointer encoding, default sync byte and the sample/tag width check.
package pdm_sched_pkg;

  localparam int BYTE_BITS = 8;
  localparam int CH_IDX_BITS = 3;
  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    WAIT = 2'd3
  } state_e;

  // PTR_DONE marks a frame whose checksum has already been issued.
  typedef enum logic [1:0] {
    PTR_SYNC = 2'd0,
    PTR_CH   = 2'd1,
    PTR_CSUM = 2'd2,
    PTR_DONE = 2'd3
  } ptr_kind_e;

  function automatic bit width_ok(input int data_bits, input int tag_bits);
    return (data_bits + tag_bits) == BYTE_BITS;
  endfunction

endpackage

// File: rtl/pdm_chan_capture.sv
// Per-channel sample holder: latches the latest strobed sample, tracks whether
// it is still waiting for a frame, and flags overwrites of a pending sample.
module pdm_chan_capture #(
  parameter int DATA_BITS = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid,
  input  logic                 enable,
  input  logic                 clear,
  input  logic [DATA_BITS-1:0] data_in,
  output logic [DATA_BITS-1:0] held_data,
  output logic                 pending,
  output logic                 overrun
);

  logic [DATA_BITS-1:0] held_q, held_d;
  logic                 pending_q, pending_d;
  logic                 accept;

  // A strobe in the snapshot cycle belongs to the next frame, so it is not an overrun.
  always_comb begin
    accept    = valid && enable;
    held_d    = accept ? data_in : held_q;
    pending_d = accept ? 1'b1 : (clear ? 1'b0 : pending_q);
    overrun   = accept && pending_q && !clear;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      held_q    <= '0;
      pending_q <= 1'b0;
    end else begin
      held_q    <= held_d;
      pending_q <= pending_d;
    end
  end

  assign held_data = held_q;
  assign pending   = pending_q;

endmodule

// File: rtl/pdm_frame_scheduler.sv
// Collects one sample per enabled PDM channel and streams a frame
// (sync, tagged channel bytes, XOR checksum) to a busy-gated UART transmitter.
module pdm_frame_scheduler
  import pdm_sched_pkg::*;
#(
  parameter int         NUM_CH    = 4,
  parameter int         DATA_BITS = 5,
  parameter int         TAG_BITS  = 3,
  parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CH-1:0]           ch_valid,
  input  logic [NUM_CH*DATA_BITS-1:0] ch_data,
  input  logic [NUM_CH-1:0]           ch_enable,
  input  logic                        tx_busy,
  output logic [7:0]                  tx_byte,
  output logic                        tx_send,
  output logic                        frame_sent,
  output logic [7:0]                  overrun_count
);

  localparam bit WIDTH_OK = width_ok(DATA_BITS, TAG_BITS);
  localparam int IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0][DATA_BITS-1:0] held;
  logic [NUM_CH-1:0]                pending;
  logic [NUM_CH-1:0]                ovr;
  logic                             complete;
  logic                             snap;

  state_e                           state_q, state_d;
  ptr_kind_e                        ptr_kind_q, ptr_kind_d;
  logic [IDX_W-1:0]                 ptr_ch_q, ptr_ch_d;
  logic [NUM_CH-1:0][DATA_BITS-1:0] buf_data_q, buf_data_d;
  logic [NUM_CH-1:0]                buf_en_q, buf_en_d;
  logic [7:0]                       csum_q, csum_d;
  logic [7:0]                       tx_byte_q, tx_byte_d;
  logic                             tx_send_q, tx_send_d;
  logic                             frame_sent_q, frame_sent_d;
  logic [7:0]                       overrun_count_q, overrun_count_d;

  logic                             nxt_found;
  logic [IDX_W-1:0]                 nxt_idx;
  int                               from_idx;
  logic [7:0]                       chan_byte;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_cap
    pdm_chan_capture #(.DATA_BITS(DATA_BITS)) u_cap (
      .clk       (clk),
      .rst       (rst),
      .valid     (ch_valid[i]),
      .enable    (ch_enable[i]),
      .clear     (snap),
      .data_in   (ch_data[i*DATA_BITS +: DATA_BITS]),
      .held_data (held[i]),
      .pending   (pending[i]),
      .overrun   (ovr[i])
    );
  end

  always_comb begin
    complete = (|ch_enable) && (&(pending | ~ch_enable));
    snap     = (state_q == IDLE) && complete;
  end

  // Next enabled channel in the snapshot, searching upward from the current pointer.
  always_comb begin
    from_idx  = (ptr_kind_q == PTR_SYNC) ? 0 : int'(ptr_ch_q) + 1;
    nxt_found = 1'b0;
    nxt_idx   = '0;
    for (int j = 0; j < NUM_CH; j++) begin
      if (!nxt_found && buf_en_q[j] && (j >= from_idx)) begin
        nxt_found = 1'b1;
        nxt_idx   = IDX_W'(j);
      end
    end
    chan_byte = '0;
    if (WIDTH_OK) chan_byte = 8'({TAG_BITS'(ptr_ch_q), buf_data_q[ptr_ch_q]});
  end

  always_comb begin
    state_d         = state_q;
    ptr_kind_d      = ptr_kind_q;
    ptr_ch_d        = ptr_ch_q;
    buf_data_d      = buf_data_q;
    buf_en_d        = buf_en_q;
    csum_d          = csum_q;
    tx_byte_d       = tx_byte_q;
    tx_send_d       = 1'b0;
    frame_sent_d    = 1'b0;
    overrun_count_d = overrun_count_q;

    if ((|ovr) && (overrun_count_q != 8'hFF)) overrun_count_d = overrun_count_q + 8'd1;

    case (state_q)
      IDLE: begin
        if (complete) begin
          buf_data_d = held;
          buf_en_d   = ch_enable;
          ptr_kind_d = PTR_SYNC;
          ptr_ch_d   = '0;
          csum_d     = '0;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (!tx_busy) state_d = SEND;
      end
      SEND: begin
        tx_send_d = 1'b1;
        state_d   = GAP;
        case (ptr_kind_q)
          PTR_SYNC, PTR_CH: begin
            if (ptr_kind_q == PTR_SYNC) begin
              tx_byte_d = SYNC_BYTE;
            end else begin
              tx_byte_d = chan_byte;
              csum_d    = csum_q ^ chan_byte;
            end
            if (nxt_found) begin
              ptr_kind_d = PTR_CH;
              ptr_ch_d   = nxt_idx;
            end else begin
              ptr_kind_d = PTR_CSUM;
            end
          end
          PTR_CSUM: begin
            tx_byte_d    = csum_q;
            frame_sent_d = 1'b1;
            ptr_kind_d   = PTR_DONE;
          end
          default: begin
            tx_send_d  = 1'b0;
            ptr_kind_d = PTR_DONE;
          end
        endcase
      end
      GAP: begin
        state_d = (ptr_kind_q == PTR_DONE) ? IDLE : WAIT;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      ptr_kind_q      <= PTR_DONE;
      ptr_ch_q        <= '0;
      buf_data_q      <= '0;
      buf_en_q        <= '0;
      csum_q          <= '0;
      tx_byte_q       <= '0;
      tx_send_q       <= 1'b0;
      frame_sent_q    <= 1'b0;
      overrun_count_q <= '0;
    end else begin
      state_q         <= state_d;
      ptr_kind_q      <= ptr_kind_d;
      ptr_ch_q        <= ptr_ch_d;
      buf_data_q      <= buf_data_d;
      buf_en_q        <= buf_en_d;
      csum_q          <= csum_d;
      tx_byte_q       <= tx_byte_d;
      tx_send_q       <= tx_send_d;
      frame_sent_q    <= frame_sent_d;
      overrun_count_q <= overrun_count_d;
    end
  end

  assign tx_byte       = tx_byte_q;
  assign tx_send       = tx_send_q;
  assign frame_sent    = frame_sent_q;
  assign overrun_count = overrun_count_q;

endmodule

// File: tb/tb_pdm_frame_scheduler.sv
// Directed bench for pdm_frame_scheduler: expected frame bytes are queued by the
// driver and checked by a negedge monitor that also emulates the busy transmitter.
module tb_pdm_frame_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  ch_valid = '0;
  logic [19:0] ch_data = '0;
  logic [3:0]  ch_enable = '0;
  logic        tx_busy = 1'b0;
  logic [7:0]  tx_byte;
  logic        tx_send;
  logic        frame_sent;
  logic [7:0]  overrun_count;

  logic [8:0]  exp_q[$];
  logic [8:0]  exp_v;
  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          n_sends = 0;
  int          last_send_cyc = 0;
  int          busy_len = 0;
  int          busy_cnt = 0;

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, queue depth %0d", exp_q.size());
    $fatal(1, "watchdog expired");
  end

  pdm_frame_scheduler #(
    .NUM_CH(4), .DATA_BITS(5), .TAG_BITS(3), .SYNC_BYTE(8'hA5)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ch_valid      (ch_valid),
    .ch_data       (ch_data),
    .ch_enable     (ch_enable),
    .tx_busy       (tx_busy),
    .tx_byte       (tx_byte),
    .tx_send       (tx_send),
    .frame_sent    (frame_sent),
    .overrun_count (overrun_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // scoreboard monitor plus transmitter busy model
  always @(negedge clk) begin
    cyc++;
    if (tx_send) begin
      check("tx_send while busy", 32'(tx_busy), 32'd0);
      if (n_sends > 0) check("tx_send spacing >= 3", 32'((cyc - last_send_cyc) >= 3), 32'd1);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected tx_send: got byte %0h, required no send", tx_byte);
      end else begin
        exp_v = exp_q.pop_front();
        check("tx byte {frame_sent,byte}", 32'({frame_sent, tx_byte}), 32'(exp_v));
      end
      n_sends++;
      last_send_cyc = cyc;
      if (busy_len > 0) busy_cnt = busy_len;
    end else begin
      if (frame_sent) check("frame_sent without tx_send", 32'(frame_sent), 32'd0);
      if (busy_cnt > 0) busy_cnt--;
    end
    tx_busy = (busy_cnt > 0);
  end

  // driver helpers
  function automatic logic [19:0] pk(input int d0, input int d1, input int d2, input int d3);
    return {5'(d3), 5'(d2), 5'(d1), 5'(d0)};
  endfunction

  task automatic push(input logic [7:0] b, input logic last);
    exp_q.push_back({last, b});
  endtask

  task automatic strobe(input logic [3:0] mask, input logic [19:0] data);
    @(posedge clk); #1;
    ch_valid = mask;
    ch_data  = data;
    @(posedge clk); #1;
    ch_valid = '0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("frame drained within budget", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (6) @(posedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " tx_byte"}, 32'(tx_byte), 32'd0);
    check({tag, " tx_send"}, 32'(tx_send), 32'd0);
    check({tag, " frame_sent"}, 32'(frame_sent), 32'd0);
    check({tag, " overrun_count"}, 32'(overrun_count), 32'd0);
  endtask

  initial begin
    int base;
    int n;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // all four channels, unbusy transmitter, plus first-byte latency
    ch_enable = 4'hF;
    push(8'hA5, 0); push(8'h03, 0); push(8'h27, 0); push(8'h4B, 0); push(8'h7F, 0); push(8'h10, 1);
    strobe(4'hF, pk(3, 7, 11, 31));
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("latency tx_send at t+4", 32'(tx_send), 32'd1);
    check("latency first byte", 32'(tx_byte), 32'hA5);
    drain(200);

    // sparse enable: channels 1 and 3 strobes are ignored
    ch_enable = 4'b0101;
    push(8'hA5, 0); push(8'h05, 0); push(8'h49, 0); push(8'h4C, 1);
    strobe(4'hF, pk(5, 17, 9, 30));
    drain(200);
    check("no overrun from disabled channels", 32'(overrun_count), 32'd0);

    // transmitter busy for 20 cycles after every load
    busy_len = 20;
    ch_enable = 4'hF;
    push(8'hA5, 0); push(8'h01, 0); push(8'h22, 0); push(8'h43, 0); push(8'h64, 0); push(8'h04, 1);
    strobe(4'hF, pk(1, 2, 3, 4));
    drain(600);
    busy_len = 0;
    repeat (25) @(posedge clk);

    // channel 0 overwritten twice before the set completes
    strobe(4'h1, pk(10, 0, 0, 0));
    strobe(4'h1, pk(12, 0, 0, 0));
    check("overrun after one overwrite", 32'(overrun_count), 32'd1);
    strobe(4'h1, pk(14, 0, 0, 0));
    check("overrun after two overwrites", 32'(overrun_count), 32'd2);
    push(8'hA5, 0); push(8'h0E, 0); push(8'h21, 0); push(8'h42, 0); push(8'h63, 0); push(8'h0E, 1);
    strobe(4'hE, pk(0, 1, 2, 3));
    drain(200);

    // strobes in the snapshot cycle queue a second frame without overrun
    push(8'hA5, 0); push(8'h08, 0); push(8'h29, 0); push(8'h4A, 0); push(8'h6C, 0); push(8'h07, 1);
    push(8'hA5, 0); push(8'h10, 0); push(8'h31, 0); push(8'h52, 0); push(8'h60, 0); push(8'h13, 1);
    @(posedge clk); #1;
    ch_valid = 4'hF;
    ch_data  = pk(8, 9, 10, 12);
    @(posedge clk); #1;
    ch_data  = pk(16, 17, 18, 0);
    @(posedge clk); #1;
    ch_valid = '0;
    drain(300);
    check("overrun unchanged by snapshot-cycle strobe", 32'(overrun_count), 32'd2);

    // 300 further overwrites saturate the counter
    @(posedge clk); #1;
    ch_valid = 4'h1;
    ch_data  = pk(20, 0, 0, 0);
    repeat (301) @(posedge clk);
    #1;
    ch_valid = '0;
    check("overrun saturates at 255", 32'(overrun_count), 32'd255);
    push(8'hA5, 0); push(8'h14, 0); push(8'h25, 0); push(8'h46, 0); push(8'h67, 0); push(8'h10, 1);
    strobe(4'hE, pk(0, 5, 6, 7));
    drain(200);

    // reset after the second byte of a frame
    push(8'hA5, 0); push(8'h01, 0); push(8'h21, 0); push(8'h41, 0); push(8'h61, 0); push(8'h00, 1);
    base = n_sends;
    strobe(4'hF, pk(1, 1, 1, 1));
    n = 0;
    while (n_sends < base + 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("two bytes before reset", 32'(n_sends - base), 32'd2);
    rst = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("mid-frame reset");
    rst = 1'b0;
    base = n_sends;
    repeat (30) @(posedge clk);
    check("no tx_send after reset", 32'(n_sends - base), 32'd0);
    push(8'hA5, 0); push(8'h02, 0); push(8'h24, 0); push(8'h46, 0); push(8'h68, 0); push(8'h08, 1);
    strobe(4'hF, pk(2, 4, 6, 8));
    drain(200);

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
